ifetch_queue: RTL

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue_if.sv | 28 ++
 rtl/ifetch_queue.sv | 103 ++++++++++
 2 files changed

// File: rtl/ifetch_queue_if.sv
// rtl/ifetch_queue_if.sv - fetch-side bus: instruction memory, decode handshake, redirect
interface ifetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          imem_read;
  logic [15:0]   imem_address;
  logic          imem_resp;
  logic [15:0]   imem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_instr;
  logic [15:0]   out_pc;
  logic          redirect;
  logic [15:0]   redirect_pc;
  logic [CW-1:0] count;

  modport master (
    output imem_read, imem_address, out_valid, out_instr, out_pc, count,
    input  imem_resp, imem_rdata, out_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_read, imem_address, out_valid, out_instr, out_pc, count,
    output imem_resp, imem_rdata, out_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction prefetch queue with single outstanding read and redirect flush
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic           clk,
  input  logic           reset_n,
  ifetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  logic [1:0]    state;
  logic [15:0]   fetch_pc;
  logic [15:0]   req_addr;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] cnt;
  logic [15:0]   q_instr [DEPTH];
  logic [15:0]   q_pc    [DEPTH];

  logic full;
  logic do_enq;
  logic do_deq;
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = bus.redirect_pc[0];

  assign full   = (cnt == CW'(DEPTH));
  assign do_enq = (state == REQ) && bus.imem_resp && !bus.redirect;
  assign do_deq = (cnt != '0) && bus.out_ready && !bus.redirect;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= '0;
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else begin
      if (bus.redirect) begin
        head     <= '0;
        tail     <= '0;
        cnt      <= '0;
        fetch_pc <= {bus.redirect_pc[15:1], 1'b0};
      end else begin
        if (do_enq) begin
          q_instr[tail] <= bus.imem_rdata;
          q_pc[tail]    <= req_addr;
          tail          <= tail + 1'b1;
          fetch_pc      <= fetch_pc + 16'd2;
        end
        if (do_deq) begin
          head <= head + 1'b1;
        end
        case ({do_enq, do_deq})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end

      // Issue only with a free slot, so the eventual response can always be enqueued.
      case (state)
        IDLE: begin
          if (!bus.redirect && !full) begin
            req_addr <= fetch_pc;
            state    <= REQ;
          end
        end
        REQ: begin
          if (bus.imem_resp) begin
            state <= IDLE;
          end else if (bus.redirect) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (bus.imem_resp) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.imem_read    = (state != IDLE);
  assign bus.imem_address = req_addr;
  assign bus.out_valid    = (cnt != '0);
  assign bus.out_instr    = q_instr[head];
  assign bus.out_pc       = q_pc[head];
  assign bus.count        = cnt;
endmodule
